// File: rtl/mips_fetch_pkg.sv
// Shared types for the instruction fetch path: FSM states and queue entries.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } fetch_state_t;

  localparam int BYTES_PER_WORD = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue of assembled instruction words with single-edge flush.
module fetch_fifo
  import mips_fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  localparam int PTR_W = $clog2(FIFO_DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     wdata,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign do_pop = pop && (count != '0);

  // Pointer and occupancy bookkeeping; flush empties the queue in one edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  // Entry storage; contents need no reset since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch_sequencer.sv
// Byte-serial instruction fetch: issues 4 byte reads per word, packs them
// big-endian, prefetches into a small queue and flushes on redirect.
module ifetch_sequencer
  import mips_fetch_pkg::*;
#(
  parameter int          ADDR_W     = 8,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t      state;
  fetch_state_t      state_nx;
  logic [ADDR_W-1:0] fetch_pc;
  logic [1:0]        byte_idx;
  logic              pending;
  logic              rd_en_q;
  logic [1:0]        recv_idx;
  logic [23:0]       asm_bytes;
  logic [ADDR_W-1:0] word_pc;
  logic [CNT_W-1:0]  count;
  logic              word_done;
  logic              push;
  logic              pop;
  logic              slot_free;
  logic              word_start;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;
  logic              unused_pc_bits;

  // Upper and sub-word redirect bits are deliberately ignored
  assign unused_pc_bits = ^{redirect_pc[31:ADDR_W], redirect_pc[1:0]};

  // A new word may only start if its eventual push is guaranteed a slot
  assign slot_free  = (32'(count) + 32'(pending)) < FIFO_DEPTH;
  assign word_start = mem_rd_en && (byte_idx == 2'd0);
  assign word_done  = rd_en_q && (recv_idx == 2'd3);
  assign push       = word_done && !redirect;
  assign pop        = instr_valid && instr_ready && !redirect;
  assign push_entry = '{pc: 32'(word_pc), instr: {asm_bytes, mem_rdata}};

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and read strobe; redirect restarts issue immediately if running
  always_comb begin
    state_nx  = state;
    mem_rd_en = 1'b0;
    case (state)
      IDLE: begin
        if (run && slot_free) state_nx = ISSUE;
      end
      ISSUE: begin
        mem_rd_en = 1'b1;
        if (byte_idx == 2'd3) state_nx = (run && slot_free) ? ISSUE : WAIT;
      end
      WAIT: begin
        if (run && slot_free)      state_nx = ISSUE;
        else if (!run && !pending) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (redirect) state_nx = run ? ISSUE : IDLE;
  end

  assign mem_addr = mem_rd_en ? (fetch_pc + ADDR_W'(byte_idx)) : '0;

  // Fetch pointer, word reservation and read-return tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= {RESET_PC[ADDR_W-1:2], 2'b00};
      byte_idx <= 2'd0;
      pending  <= 1'b0;
      rd_en_q  <= 1'b0;
      recv_idx <= 2'd0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      byte_idx <= 2'd0;
      pending  <= 1'b0;
      rd_en_q  <= 1'b0;
      recv_idx <= 2'd0;
    end else begin
      rd_en_q <= mem_rd_en;
      if (rd_en_q) recv_idx <= recv_idx + 2'd1;
      if (mem_rd_en) begin
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) fetch_pc <= fetch_pc + ADDR_W'(BYTES_PER_WORD);
      end
      if (word_start)     pending <= 1'b1;
      else if (word_done) pending <= 1'b0;
    end
  end

  // Byte assembly shift register and address of the word being assembled
  always_ff @(posedge clk) begin
    if (rd_en_q)    asm_bytes <= {asm_bytes[15:0], mem_rdata};
    if (word_start) word_pc   <= fetch_pc;
  end

  fetch_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .flush(redirect),
    .wdata(push_entry),
    .head (head),
    .count(count)
  );

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? head.instr : 32'h0;
  assign instr_pc    = instr_valid ? head.pc    : 32'h0;

endmodule

// File: tb/tb_ifetch_sequencer.sv
// Directed bench for ifetch_sequencer with a registered byte RAM model and
// an expected-word scoreboard.
module tb_ifetch_sequencer;

  logic        clk;
  logic        rst;
  logic        run;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  logic [7:0]  ram [256];
  logic [63:0] exp_q [$];
  int          checks;
  int          failures;

  ifetch_sequencer #(
    .ADDR_W    (8),
    .RESET_PC  (32'h0),
    .FIFO_DEPTH(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .instr_pc   (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read instruction RAM
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= ram[mem_addr];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_word(input logic [7:0] pc);
    return {ram[pc], ram[pc + 8'd1], ram[pc + 8'd2], ram[pc + 8'd3]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input logic [7:0] pc);
    exp_q.push_back({32'(pc), exp_word(pc)});
  endtask

  task automatic pop_check(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_unexpected_pc"}, instr_pc, 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_pc"}, instr_pc, e[63:32]);
      chk({tag, "_instr"}, instr, e[31:0]);
    end
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    instr_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 200) begin
      if (instr_valid) pop_check(tag);
      @(negedge clk);
      guard++;
    end
    chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    repeat (5) @(negedge clk);
    chk({tag, "_quiet_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_quiet_rd"}, 32'(mem_rd_en), 32'd0);
    instr_ready = 1'b0;
  endtask

  task automatic wait_rd(input string tag);
    int guard = 0;
    while (!mem_rd_en && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_rd_seen"}, 32'(mem_rd_en), 32'd1);
  endtask

  task automatic wait_addr(input string tag, input logic [7:0] a);
    int guard = 0;
    while (!(mem_rd_en && mem_addr == a) && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_addr_seen"}, 32'(mem_addr), 32'(a));
  endtask

  task automatic wait_valid(input string tag);
    int guard = 0;
    while (!instr_valid && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_valid_seen"}, 32'(instr_valid), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_instr_pc"}, instr_pc, 32'd0);
  endtask

  initial begin
    logic any_rd;
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    run         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i * 37 + 11);
    ram[0] = 8'h20; ram[1] = 8'h08; ram[2] = 8'h00; ram[3] = 8'h05;

    // Step 1: reset state, first fetch and latency
    repeat (2) @(negedge clk);
    chk_reset_outputs("s1_reset");
    rst = 1'b0;
    run = 1'b1;
    expect_word(8'h00);
    expect_word(8'h04);
    wait_rd("s1");
    for (int i = 0; i < 4; i++) begin
      chk("s1_rd_en", 32'(mem_rd_en), 32'd1);
      chk("s1_addr", 32'(mem_addr), 32'(i));
      @(negedge clk);
    end
    chk("s1_lat_n4_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    chk("s1_lat_n5_valid", 32'(instr_valid), 32'd1);
    chk("s1_instr_const", instr, 32'h2008_0005);
    chk("s1_instr_pc", instr_pc, exp_q[0][63:32]);

    // Step 2: backpressure fills the queue, issue stops, one pop restarts at pc 8
    repeat (10) @(negedge clk);
    any_rd = 1'b0;
    repeat (8) begin
      if (mem_rd_en) any_rd = 1'b1;
      @(negedge clk);
    end
    chk("s2_full_no_rd", 32'(any_rd), 32'd0);
    chk("s2_head_stable", instr, exp_q[0][31:0]);
    chk("s2_head_pc_stable", instr_pc, exp_q[0][63:32]);
    instr_ready = 1'b1;
    pop_check("s2_pop");
    @(negedge clk);
    instr_ready = 1'b0;
    wait_rd("s2");
    chk("s2_restart_addr", 32'(mem_addr), 32'h08);
    expect_word(8'h08);
    run = 1'b0;
    drain("s2_drain");

    // Step 3: redirect while the word at pc 4 is half assembled
    run         = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    @(negedge clk);
    redirect = 1'b0;
    wait_addr("s3", 8'h06);
    chk("s3_pre_valid", 32'(instr_valid), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h43;
    @(negedge clk);
    redirect = 1'b0;
    run      = 1'b0;
    chk("s3_flush_valid", 32'(instr_valid), 32'd0);
    chk("s3_issue_rd", 32'(mem_rd_en), 32'd1);
    chk("s3_issue_addr", 32'(mem_addr), 32'h40);
    expect_word(8'h40);
    drain("s3_drain");

    // Step 4: redirect coinciding with a pop of a valid head
    run         = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    @(negedge clk);
    redirect = 1'b0;
    wait_valid("s4");
    chk("s4_old_head_pc", instr_pc, 32'h80);
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFA2;
    @(negedge clk);
    redirect = 1'b0;
    run      = 1'b0;
    chk("s4_flush_valid", 32'(instr_valid), 32'd0);
    chk("s4_issue_addr", 32'(mem_addr), 32'hA0);
    expect_word(8'hA0);
    drain("s4_drain");

    // Step 5: address wrap from FC to 00
    instr_ready = 1'b1;
    run         = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFC;
    expect_word(8'hFC);
    expect_word(8'h00);
    @(negedge clk);
    redirect = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("s5_wrap_rd", 32'(mem_rd_en), 32'd1);
      chk("s5_wrap_addr", 32'(mem_addr), 32'((8'hFC + 8'(i)) & 8'hFF));
      if (i < 4) @(negedge clk);
    end
    run = 1'b0;
    drain("s5_drain");

    // Step 6: asynchronous reset with a word in flight and one queued
    run = 1'b1;
    wait_addr("s6", 8'h0A);
    chk("s6_pre_valid", 32'(instr_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("s6_async");
    @(negedge clk);
    rst = 1'b0;
    wait_rd("s6");
    chk("s6_restart_addr", 32'(mem_addr), 32'h00);
    expect_word(8'h00);
    run = 1'b0;
    drain("s6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
